// File: rtl/seg_share_arbiter.sv
// Round-robin owner arbitration for the eight shared seven-segment digits.
// The grant has a guaranteed minimum hold and is preempted after a bounded maximum under contention.
module seg_share_arbiter #(
  parameter int unsigned MIN_HOLD = 16,
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [7:0]  mask0,
  input  logic [7:0]  mask1,
  input  logic [7:0]  mask2,
  input  logic [7:0]  mask3,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        preempt,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam logic [CNT_W-1:0] MinHold = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] KOne    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StLock, StOpen} state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             preempt_q, preempt_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       mask_q, mask_d;

  logic [3:0][31:0] data_arr;
  logic [3:0][7:0]  mask_arr;
  logic [3:0]       others;
  logic [2:0]       pick_any, pick_oth;
  logic             grant, go_idle;
  logic [1:0]       win;
  logic [7:0][7:0]  seg_v;

  assign data_arr = {data3, data2, data1, data0};
  assign mask_arr = {mask3, mask2, mask1, mask0};

  // Returns {found, index}; the scan starts just after the previous winner.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (r[idx] && !res[2]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    logic [7:0] s;
    unique case (h)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    k_d       = k_q;
    preempt_d = 1'b0;
    data_d    = data_q;
    mask_d    = mask_q;
    grant     = 1'b0;
    go_idle   = 1'b0;
    win       = 2'd0;

    others   = req & ~(4'b0001 << owner_q);
    pick_any = rr_pick(req, last_q);
    pick_oth = rr_pick(others, last_q);

    unique case (state_q)
      StIdle: begin
        if (pick_any[2]) begin
          grant = 1'b1;
          win   = pick_any[1:0];
        end
      end
      StOpen: begin
        if (!req[owner_q]) begin
          if (pick_oth[2]) begin
            grant = 1'b1;
            win   = pick_oth[1:0];
          end else begin
            go_idle = 1'b1;
            state_d = StIdle;
          end
        end else if (pick_oth[2] && k_q >= MaxHold) begin
          grant     = 1'b1;
          win       = pick_oth[1:0];
          preempt_d = 1'b1;
        end
      end
      default: ;  // StLock: owner keeps the grant whatever req does
    endcase

    if (grant) begin
      owner_d = win;
      last_d  = win;
      k_d     = KOne;
      state_d = (KOne >= MinHold) ? StOpen : StLock;
      data_d  = data_arr[win];
      mask_d  = mask_arr[win];
    end else if (state_q != StIdle && !go_idle) begin
      if (k_q < MaxHold) k_d = k_q + KOne;
      state_d = (k_d >= MinHold) ? StOpen : StLock;
      // Dropping req freezes the displayed value until ownership ends.
      if (req[owner_q]) begin
        data_d = data_arr[owner_q];
        mask_d = mask_arr[owner_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      k_q       <= '0;
      preempt_q <= 1'b0;
      data_q    <= 32'h0;
      mask_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      k_q       <= k_d;
      preempt_q <= preempt_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign owner   = owner_q;
  assign gnt     = busy ? (4'b0001 << owner_q) : 4'b0000;
  assign preempt = preempt_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (!busy || !mask_q[i]) seg_v[i] = 8'hFF;
      else seg_v[i] = hex2seg(data_q[4*i +: 4]);
    end
  end

  assign seg0 = seg_v[0];
  assign seg1 = seg_v[1];
  assign seg2 = seg_v[2];
  assign seg3 = seg_v[3];
  assign seg4 = seg_v[4];
  assign seg5 = seg_v[5];
  assign seg6 = seg_v[6];
  assign seg7 = seg_v[7];

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Self-checking bench for seg_share_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural ownership model.
module tb_seg_share_arbiter;

  localparam int MinHold = 16;
  localparam int MaxHold = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data [4];
  logic [7:0]  mask [4];
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        preempt;
  logic [7:0]  seg [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit        m_busy;
  int        m_owner;
  int        m_last;
  int        m_k;
  bit        m_pre;
  bit [31:0] m_data;
  bit [7:0]  m_mask;
  bit [7:0]  hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  seg_share_arbiter #(
    .MIN_HOLD(MinHold),
    .MAX_HOLD(MaxHold),
    .CNT_W   (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data0  (data[0]),
    .data1  (data[1]),
    .data2  (data[2]),
    .data3  (data[3]),
    .mask0  (mask[0]),
    .mask1  (mask[1]),
    .mask2  (mask[2]),
    .mask3  (mask[3]),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .preempt(preempt),
    .seg0   (seg[0]),
    .seg1   (seg[1]),
    .seg2   (seg[2]),
    .seg3   (seg[3]),
    .seg4   (seg[4]),
    .seg5   (seg[5]),
    .seg6   (seg[6]),
    .seg7   (seg[7])
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_segs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = seg[i];
    return v;
  endfunction

  function automatic logic [63:0] model_segs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      if (!m_busy || !m_mask[i]) v[8*i +: 8] = 8'hFF;
      else v[8*i +: 8] = hex_tab[m_data[4*i +: 4]];
    end
    return v;
  endfunction

  // First requester with req set, scanning round-robin after 'last'; skips 'excl'.
  function automatic int rr(input logic [3:0] r, input int last, input int excl);
    for (int d = 1; d <= 4; d++) begin
      int c;
      c = (last + d) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = 3;
    m_k     = 0;
    m_pre   = 0;
    m_data  = 0;
    m_mask  = 0;
  endtask

  task automatic model_update();
    int w;
    bit pre;
    bit leave;
    if (rst) begin
      model_reset();
      return;
    end
    w = -1;
    pre = 0;
    leave = 0;
    if (!m_busy) begin
      w = rr(req, m_last, -1);
    end else if (m_k >= MinHold) begin
      if (!req[m_owner]) begin
        w = rr(req, m_last, m_owner);
        leave = (w < 0);
      end else if (m_k >= MaxHold) begin
        w = rr(req, m_last, m_owner);
        pre = (w >= 0);
      end
    end
    m_pre = pre;
    if (w >= 0) begin
      m_busy  = 1;
      m_owner = w;
      m_last  = w;
      m_k     = 1;
      m_data  = data[w];
      m_mask  = mask[w];
    end else if (leave) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_k < MaxHold) m_k++;
      if (req[m_owner]) begin
        m_data = data[m_owner];
        m_mask = mask[m_owner];
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_gnt;
    exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check_eq("gnt", 64'(gnt), 64'(exp_gnt));
    check_eq("busy", 64'(busy), 64'(m_busy));
    check_eq("preempt", 64'(preempt), 64'(m_pre));
    if (m_busy) check_eq("owner", 64'(owner), 64'(m_owner));
    check_eq("segs", dut_segs(), model_segs());
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    cycle();
    rst = 1'b0;
  endtask

  int cnt;
  int n_pre;
  int n_zero;

  initial begin
    rst = 1'b1;
    req = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      mask[i] = 8'($urandom);
    end
    model_reset();
    #1;
    check_eq("rst_gnt", 64'(gnt), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_segs", dut_segs(), {8{8'hFF}});
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    req = 4'b0000;
    cycle();
    cycle();
    check_eq("rel_segs", dut_segs(), {8{8'hFF}});

    // Single requester, live display of its value
    req = 4'b0010;
    data[1] = 32'h1234_5678;
    mask[1] = 8'hFF;
    cycle();
    check_eq("t2_gnt", 64'(gnt), 64'h2);
    check_eq("t2_owner", 64'(owner), 64'h1);
    check_eq("t2_seg0", 64'(seg[0]), 64'h01);
    check_eq("t2_seg1", 64'(seg[1]), 64'h1F);
    check_eq("t2_seg7", 64'(seg[7]), 64'h9F);
    mask[1] = 8'h0F;
    cycle();
    check_eq("t2_mask_hi", 64'({seg[7], seg[6], seg[5], seg[4]}), 64'hFFFF_FFFF);
    check_eq("t2_mask_lo", 64'(seg[0]), 64'h01);

    // Minimum hold after a short pulse
    do_reset();
    data[0] = 32'h0;
    mask[0] = 8'hFF;
    cnt = 0;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (gnt == 4'b0001) cnt++;
    end
    req = 4'b0000;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (gnt == 4'b0001) begin
        cnt++;
        check_eq("t3_seg", dut_segs(), {8{8'h03}});
      end
    end
    check_eq("t3_hold_len", 64'(cnt), 64'(MinHold));
    check_eq("t3_idle_segs", dut_segs(), {8{8'hFF}});

    // Contention: preempt after maximum hold
    do_reset();
    req = 4'b0101;
    n_pre = 0;
    n_zero = 0;
    for (int i = 1; i <= 600; i++) begin
      data[0] = $urandom;
      data[2] = $urandom;
      mask[0] = 8'($urandom);
      mask[2] = 8'($urandom);
      cycle();
      if (preempt) n_pre++;
      if (gnt == 4'b0000) n_zero++;
      if (i == MaxHold) check_eq("t4_before", 64'(gnt), 64'h1);
      if (i == MaxHold + 1) begin
        check_eq("t4_pre_gnt", 64'(gnt), 64'h4);
        check_eq("t4_pre_pulse", 64'(preempt), 64'h1);
      end
      if (i == 2 * MaxHold + 1) check_eq("t4_back", 64'(gnt), 64'h1);
    end
    check_eq("t4_pre_count", 64'(n_pre), 64'h2);
    check_eq("t4_no_gap", 64'(n_zero), 64'h0);

    // Owner releases with two others pending: RR after 1 picks 3
    do_reset();
    mask[3] = 8'hFF;
    req = 4'b0010;
    cycle();
    req = 4'b1011;
    for (int i = 0; i < 39; i++) cycle();
    req = 4'b1001;
    cycle();
    check_eq("t5_gnt", 64'(gnt), 64'h8);
    check_eq("t5_preempt", 64'(preempt), 64'h0);
    check_eq("t5_busy", 64'(busy), 64'h1);

    // Asynchronous reset mid-cycle during ownership
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 5; i++) cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_gnt", 64'(gnt), 64'h0);
    check_eq("t6_busy", 64'(busy), 64'h0);
    check_eq("t6_segs", dut_segs(), {8{8'hFF}});
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    cycle();
    check_eq("t6_first", 64'(gnt), 64'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        data[j] = $urandom;
        if ($urandom_range(0, 3) == 0) mask[j] = 8'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_share_arbiter.md
Name: seg_share_arbiter

Overview:
Round-robin arbiter and controller that shares the eight seven-segment digits (seg0..seg7) between four independent requesters, such as the keyboard FSM, LFSR demo, ALU demo and debug counter. A requester raises req and drives a 32-bit hex value plus an 8-bit digit-enable mask. The granted owner's value is registered and decoded to active-low segment patterns. Ownership has a guaranteed minimum hold and a bounded maximum hold under contention, so no requester can starve another.

Parameters:
MIN_HOLD, 16, minimum ownership length in cycles (>=1).
MAX_HOLD, 256, ownership length after which a contended owner is preempted (>MIN_HOLD).
CNT_W, 16, hold-counter width; must represent MAX_HOLD.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  4  request per requester; bit i = requester i
data0..data3  in  32 each  hex value; nibble [4k+3:4k] drives digit k
mask0..mask3  in  8 each  digit enable; bit k=0 blanks digit k
gnt  out  4  one-hot grant, registered
owner  out  2  index of current owner; valid when busy=1
busy  out  1  a grant is active
preempt  out  1  one-cycle pulse in the first cycle of a grant won by forced preemption
seg0..seg7  out  8 each  active-low {a,b,c,d,e,f,g,dp}; dp always 1; blank = 8'hFF

Behaviour:
- Reset (async, immediate):
  - gnt=0, owner=0, busy=0, preempt=0.
  - All seg outputs 8'hFF; latched data=0, latched mask=0.
  - Round-robin pointer last=3, so requester 0 has first priority.
  - Reset asserted mid-ownership drops the grant in the same cycle, with no handoff.
- States:
  - IDLE: no owner.
  - LOCK: owner holding, ownership count k<MIN_HOLD.
  - OPEN: owner holding, k>=MIN_HOLD.
  - k=1 in the first cycle gnt is high; it increments each cycle and saturates at MAX_HOLD.
- Arbitration:
  - Winner = first set req bit scanning (last+1)%4, (last+2)%4, … .
  - On every new grant: last<=winner, k<=1, and gnt/owner/busy update at the same edge.
- IDLE: any req high at edge t gives gnt valid from cycle t+1. Latency is 1 cycle.
- LOCK: the owner keeps the grant regardless of req.
  - If the owner's req drops, latched data/mask freeze at their last sampled values.
  - When k reaches MIN_HOLD, the state becomes OPEN.
- OPEN, evaluated each edge in priority order:
  - Owner req low, another req pending: hand off directly to the RR winner among the others. No blank cycle between owners.
  - Owner req low, none pending: go to IDLE; segs become 8'hFF the next cycle.
  - Owner req high, another req pending, k>=MAX_HOLD: preempt to the RR winner excluding the owner; preempt=1 for the first cycle of the new grant.
  - Otherwise hold.
- Data capture:
  - While busy and req[owner]=1, data_owner/mask_owner are registered every cycle, so the display tracks live updates with 1 cycle latency.
  - On a new grant, the new owner's data/mask are captured at the grant edge.
- Decode (combinational from latched regs):
  - Digit k = 8'hFF if IDLE or mask bit k=0.
  - Otherwise hex pattern: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71.
- Simultaneous events:
  - Requests arriving in the same cycle as a handoff are considered in that handoff's RR scan.
  - Non-owner data/mask are ignored.
- Invariant: gnt is zero or one-hot, and gnt[owner]==busy at all times.

Test Plan:
1. Reset with random req/data, rst=1 → gnt=0, busy=0, all seg=FF; release rst with req=0 → outputs unchanged.
2. req=0010, data1=32'h1234_5678, mask1=8'hFF → gnt=0010 one cycle later, owner=1; seg0=01 ('8'), seg1=1F ('7'), seg7=9F ('1'); set mask1=8'h0F → seg4..seg7=FF next cycle.
3. MIN_HOLD=16, req0 pulsed 3 cycles with data0=32'h0 → gnt0 high exactly 16 cycles, seg0..7=03 throughout, then gnt=0 and segs FF.
4. MAX_HOLD=256, req0 and req2 held high continuously → gnt 0001 for 256 cycles, then 0100 with preempt=1 for one cycle, 256 cycles later 0001 again; never 0 between owners.
5. Owner 1 drops req at k=40 while req3 and req0 are both pending → next cycle gnt=1000 (RR after 1 picks 3), preempt=0, no blank digit cycle.
6. Assert rst asynchronously mid-cycle during ownership → gnt/busy go to 0 and segs to FF before the next clk edge; after release, the next grant favours requester 0.
